// File: rtl/de_reg.sv
`default_nettype none
// ============================================================================
// Module      : de_reg
// Description : D->E pipeline register with stall-bubble insertion, flush,
//               Tnew decrement and a saturating bubble counter.
//               All outputs are taken directly from flops. There is no
//               combinational path from any input to any output.
//
//               Ports:
//                 clk, reset         clock; async active-high reset
//                 stall, flush       hazard stall (bubble) / flush request
//                 d_*                D-stage instruction fields
//                 e_*                registered E-stage copies
//                 bubble_cnt         bubbles inserted by stall (saturating)
//
//               Optional feature macro: DE_EXC_EN
//                 Adds d_exccode/e_exccode (5b) and d_bd/e_bd (1b).
//
// Revision    : 1.0 - initial release
// ============================================================================
module de_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        d_valid,
    input  logic [31:0] d_pc,
    input  logic [31:0] d_instr,
    input  logic [31:0] d_rs_data,
    input  logic [31:0] d_rt_data,
    input  logic [31:0] d_ext,
    input  logic [4:0]  d_wa,
    input  logic [1:0]  d_tnew,
`ifdef DE_EXC_EN
    input  logic [4:0]  d_exccode,
    input  logic        d_bd,
    output logic [4:0]  e_exccode,
    output logic        e_bd,
`endif
    output logic        e_valid,
    output logic [31:0] e_pc,
    output logic [31:0] e_instr,
    output logic [31:0] e_rs_data,
    output logic [31:0] e_rt_data,
    output logic [31:0] e_ext,
    output logic [4:0]  e_wa,
    output logic [1:0]  e_tnew,
    output logic [15:0] bubble_cnt
);

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_rs_data;
    logic [31:0] r_rt_data;
    logic [31:0] r_ext;
    logic [4:0]  r_wa;
    logic [1:0]  r_tnew;
    logic [15:0] r_bubble_cnt;

    logic [1:0]  w_tnew_load;
    logic [4:0]  w_wa_load;
    logic [15:0] w_cnt_next;

    // A non-valid slot in D must never look like a pending register write,
    // so both the destination and the Tnew are forced to zero for it.
    always_comb begin
        w_tnew_load = 2'd0;
        w_wa_load   = 5'd0;
        if (d_valid) begin
            w_wa_load   = d_wa;
            w_tnew_load = (d_tnew == 2'd0) ? 2'd0 : (d_tnew - 2'd1);
        end
    end

    assign w_cnt_next = (r_bubble_cnt == c_CNT_MAX) ? c_CNT_MAX
                                                    : (r_bubble_cnt + 16'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_pc         <= 32'd0;
            r_instr      <= 32'd0;
            r_rs_data    <= 32'd0;
            r_rt_data    <= 32'd0;
            r_ext        <= 32'd0;
            r_wa         <= 5'd0;
            r_tnew       <= 2'd0;
            r_bubble_cnt <= 16'd0;
        end else if (flush) begin
            // Flush wins over stall and does not count as a bubble.
            r_valid   <= 1'b0;
            r_pc      <= 32'd0;
            r_instr   <= 32'd0;
            r_rs_data <= 32'd0;
            r_rt_data <= 32'd0;
            r_ext     <= 32'd0;
            r_wa      <= 5'd0;
            r_tnew    <= 2'd0;
        end else if (stall) begin
            // The bubble keeps the PC of the stalled instruction so that
            // exception reporting in later stages still has a valid PC.
            r_valid      <= 1'b0;
            r_pc         <= d_pc;
            r_instr      <= 32'd0;
            r_rs_data    <= 32'd0;
            r_rt_data    <= 32'd0;
            r_ext        <= 32'd0;
            r_wa         <= 5'd0;
            r_tnew       <= 2'd0;
            r_bubble_cnt <= w_cnt_next;
        end else begin
            r_valid   <= d_valid;
            r_pc      <= d_pc;
            r_instr   <= d_instr;
            r_rs_data <= d_rs_data;
            r_rt_data <= d_rt_data;
            r_ext     <= d_ext;
            r_wa      <= w_wa_load;
            r_tnew    <= w_tnew_load;
        end
    end

`ifdef DE_EXC_EN
    logic [4:0] r_exccode;
    logic       r_bd;

    // The branch-delay flag travels with the bubble's PC; the exception code
    // of a bubble is always cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exccode <= 5'd0;
            r_bd      <= 1'b0;
        end else if (flush) begin
            r_exccode <= 5'd0;
            r_bd      <= 1'b0;
        end else if (stall) begin
            r_exccode <= 5'd0;
            r_bd      <= d_bd;
        end else begin
            r_exccode <= d_exccode;
            r_bd      <= d_bd;
        end
    end

    assign e_exccode = r_exccode;
    assign e_bd      = r_bd;
`endif

    assign e_valid    = r_valid;
    assign e_pc       = r_pc;
    assign e_instr    = r_instr;
    assign e_rs_data  = r_rs_data;
    assign e_rt_data  = r_rt_data;
    assign e_ext      = r_ext;
    assign e_wa       = r_wa;
    assign e_tnew     = r_tnew;
    assign bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire
